seg7_scan_ctrl: RTL

Time-multiplexing controller for the board's 4-digit common-anode 7-segment display. It holds a 16-bit hex value and scans one digit per slot with active-low anodes. Each slot drives the hex-decoded, active-low segment pattern and decimal point for that digit. It also provides anti-ghosting dead time, optional leading-zero suppression and frame-synchronous value updates. It sits between system logic and the display pins, replacing static single-digit drive with T tied to 1110.

---
 rtl/seg7_scan_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: scans a 4-digit common-anode 7-segment display.
// Shows a 16-bit hex value one digit per slot with active-low anodes and segments.
// Each slot starts with anti-ghosting dead time, and leading zeros can be suppressed.
// New values are taken from a pending register only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int DIV_MAX   = 99999,
  parameter int BLANK_CYC = 1000,
  parameter int CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_tick,
  output logic        upd_done
);

  localparam logic [CNT_W-1:0] DIV_MAX_C = CNT_W'(DIV_MAX);
  localparam logic [CNT_W-1:0] BLANK_C   = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shown_q, shown_d;
  logic [15:0]      pending_q, pending_d;
  logic             pend_v_q, pend_v_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             ft_q, ft_d;
  logic             ud_q, ud_d;
  logic             slot_end;
  logic             boundary;
  logic             suppress;
  logic [3:0]       nib;

  // Hex digit to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign slot_end = (cnt_q == DIV_MAX_C);
  assign boundary = slot_end && (idx_q == 2'd3);
  assign nib      = shown_q[{idx_q, 2'b00} +: 4];

  // A digit above 0 goes dark when it and every digit to its left are zero.
  always_comb begin
    suppress = 1'b0;
    if (lz_en) begin
      case (idx_q)
        2'd1:    suppress = (shown_q[15:4] == 12'h000);
        2'd2:    suppress = (shown_q[15:8] == 8'h00);
        2'd3:    suppress = (shown_q[15:12] == 4'h0);
        default: suppress = 1'b0;
      endcase
    end
  end

  // Next-state for the scan counters, value registers and registered outputs.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shown_d   = shown_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    an_d      = 4'hF;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    ft_d      = 1'b0;
    ud_d      = 1'b0;
    if (!en) begin
      // Disabled: scan parked at digit 0, display dark, updates go straight through.
      cnt_d = '0;
      idx_d = 2'd0;
      if (load) begin
        shown_d   = value;
        pending_d = value;
        pend_v_d  = 1'b0;
        ud_d      = 1'b1;
      end else if (pend_v_q) begin
        shown_d  = pending_q;
        pend_v_d = 1'b0;
        ud_d     = 1'b1;
      end
    end else begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ft_d  = boundary;
      an_d  = ((cnt_q < BLANK_C) || suppress) ? 4'hF : ~(4'b0001 << idx_q);
      seg_d = hex_to_seg(nib);
      dp_d  = ~dp_mask[idx_q];
      if (load && boundary) begin
        shown_d   = value;
        pending_d = value;
        pend_v_d  = 1'b0;
        ud_d      = 1'b1;
      end else if (load) begin
        pending_d = value;
        pend_v_d  = 1'b1;
      end else if (boundary && pend_v_q) begin
        shown_d  = pending_q;
        pend_v_d = 1'b0;
        ud_d     = 1'b1;
      end
    end
  end

  // State and output registers; reset aborts the scan and drops any pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shown_q   <= 16'h0000;
      pending_q <= 16'h0000;
      pend_v_q  <= 1'b0;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      ft_q      <= 1'b0;
      ud_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      ft_q      <= ft_d;
      ud_q      <= ud_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = ft_q;
  assign upd_done   = ud_q;

endmodule
